// File: rtl/pipeline_sequencer_if.sv
// Hazard/sequencer bus: pipeline-side instruction and memory status in,
// stall/flush controls and performance counters out.
interface pipeline_sequencer_if;
  logic [31:0] InstrD;
  logic [31:0] InstrE;
  logic        PCSrcE;
  logic        dmem_req;
  logic        dmem_ready;
  logic        StallF, StallD, StallE, StallM;
  logic        FlushD, FlushE, FlushM;
  logic        mem_timeout;
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;

  modport master (
    output InstrD, InstrE, PCSrcE, dmem_req, dmem_ready,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM,
    input  mem_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  InstrD, InstrE, PCSrcE, dmem_req, dmem_ready,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM,
    output mem_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// 5-stage pipeline sequencer: post-reset flush, memory-wait stalls, branch
// flushes and load-use interlock, with timeout flag and perf counters.
module pipeline_sequencer #(
  parameter int TIMEOUT     = 255,
  parameter int INIT_CYCLES = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  pipeline_sequencer_if.slave bus
);
  localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);
  localparam logic [7:0] WAIT_MAX  = 8'(TIMEOUT);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, MEMWAIT = 2'd2} state_t;

  state_t      state_q;
  logic [7:0]  init_cnt_q, wait_cnt_q, wait_inc;
  logic        mem_timeout_q;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  logic [4:0]  rdE;
  logic [6:0]  opD;
  logic        rs1_hit, rs2_hit, lu, memstall, run_flush, any_stall;
  logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m;
  logic        unused_bits;

  assign rdE     = bus.InstrE[11:7];
  assign opD     = bus.InstrD[6:0];
  // U/J formats carry immediate bits in the rs1 field; only R/S/B read rs2.
  assign rs1_hit = (rdE == bus.InstrD[19:15]) && !(opD inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign rs2_hit = (rdE == bus.InstrD[24:20]) && (opD inside {OP_R, OP_S, OP_B});
  assign lu      = (bus.InstrE[6:0] == OP_LOAD) && (rdE != 5'd0) && (rs1_hit || rs2_hit);
  assign memstall = (state_q != INIT) && bus.dmem_req && !bus.dmem_ready;
  assign unused_bits = ^{bus.InstrD[31:25], bus.InstrD[14:7], bus.InstrE[31:12]};

  always_comb begin
    stall_f = 1'b0; stall_d = 1'b0; stall_e = 1'b0; stall_m = 1'b0;
    flush_d = 1'b0; flush_e = 1'b0; flush_m = 1'b0;
    if (state_q == INIT) begin
      flush_d = 1'b1; flush_e = 1'b1; flush_m = 1'b1;
    end else if (memstall) begin
      stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1; stall_m = 1'b1;
      flush_m = 1'b1;
    end else if (bus.PCSrcE) begin
      flush_d = 1'b1; flush_e = 1'b1;
    end else if (lu) begin
      stall_f = 1'b1; stall_d = 1'b1; flush_e = 1'b1;
    end
  end

  assign run_flush = (state_q != INIT) && !memstall && (bus.PCSrcE || lu);
  assign any_stall = stall_f | stall_d | stall_e | stall_m;
  assign wait_inc  = wait_cnt_q + 8'd1;

  assign stall_cycles_d = (any_stall && stall_cycles_q != '1) ? stall_cycles_q + 32'd1
                                                              : stall_cycles_q;
  assign flush_events_d = (run_flush && flush_events_q != '1) ? flush_events_q + 32'd1
                                                              : flush_events_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= INIT;
      init_cnt_q     <= '0;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
      case (state_q)
        INIT: begin
          if (init_cnt_q == INIT_LAST) begin
            state_q    <= RUN;
            init_cnt_q <= '0;
          end else begin
            init_cnt_q <= init_cnt_q + 8'd1;
          end
        end
        RUN: begin
          if (memstall) begin
            state_q    <= MEMWAIT;
            wait_cnt_q <= '0;
          end
        end
        MEMWAIT: begin
          if (!memstall) state_q <= RUN;
          // No forced release: the flag only reports a stuck memory.
          if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_q <= wait_inc;
            if (wait_inc == WAIT_MAX) mem_timeout_q <= 1'b1;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign bus.StallF       = stall_f;
  assign bus.StallD       = stall_d;
  assign bus.StallE       = stall_e;
  assign bus.StallM       = stall_m;
  assign bus.FlushD       = flush_d;
  assign bus.FlushE       = flush_e;
  assign bus.FlushM       = flush_m;
  assign bus.mem_timeout  = mem_timeout_q;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_events = flush_events_q;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboarded bench for pipeline_sequencer: per-cycle expected control
// vectors are queued at drive time and compared on the falling edge.
module tb_pipeline_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pipeline_sequencer_if bus ();
  pipeline_sequencer #(.TIMEOUT(255), .INIT_CYCLES(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM}
  localparam logic [6:0] IDLE  = 7'b0000_000;
  localparam logic [6:0] INITV = 7'b0000_111;
  localparam logic [6:0] MEMS  = 7'b1111_001;
  localparam logic [6:0] BR    = 7'b0000_110;
  localparam logic [6:0] LU    = 7'b1100_010;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_IMM = 7'b0010011, OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_R = 7'b0110011, OP_S = 7'b0100011, OP_B = 7'b1100011;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct { logic [6:0] v; string tag; } exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;

  function automatic logic [31:0] enc(input logic [4:0] rs2, rs1, rd, input logic [6:0] op);
    return {7'b0, rs2, rs1, 3'b010, rd, op};
  endfunction

  function automatic logic [6:0] outs();
    return {bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.FlushD, bus.FlushE, bus.FlushM};
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      if (outs() !== e.v) $display("FAIL %s: got %b want %b", e.tag, outs(), e.v);
      else n_pass++;
    end
  end

  task automatic cyc(input logic [31:0] d, e, input logic pc, rq, rdy,
                     input logic [6:0] ex, input string tag);
    @(posedge clk); #1;
    bus.InstrD = d; bus.InstrE = e; bus.PCSrcE = pc;
    bus.dmem_req = rq; bus.dmem_ready = rdy;
    sb.push_back('{ex, tag});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(NOP, NOP, 1'b0, 1'b0, 1'b1, IDLE, "idle");
  endtask

  task automatic assert_rst();
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.push_back('{INITV, "in_reset"});
  endtask

  task automatic release_rst();
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.push_back('{INITV, "init0"});
    for (int i = 1; i < 3; i++) begin
      @(posedge clk); #1;
      sb.push_back('{INITV, "init"});
    end
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  logic [31:0] LW5, LW0, ADD_R1, ADD_R2, ADD000, ADDI_F5, LUI_F5, SW5, BEQ5, ADDI_RD5;

  task automatic test_reset();
    assert_rst();
    #1;
    n_chk++; if (bus.stall_cycles !== 32'd0 || bus.flush_events !== 32'd0 || bus.mem_timeout !== 1'b0)
      $display("FAIL reset_regs: got %0d/%0d/%b want 0/0/0", bus.stall_cycles, bus.flush_events, bus.mem_timeout);
    else n_pass++;
    release_rst();
    idle(3);
    settle();
    n_chk++; if (bus.stall_cycles !== 32'd0 || bus.flush_events !== 32'd0)
      $display("FAIL post_init_cnt: got %0d/%0d want 0/0", bus.stall_cycles, bus.flush_events);
    else n_pass++;
  endtask

  task automatic test_init_ignores();
    bus.InstrD = ADD_R1; bus.InstrE = LW5; bus.PCSrcE = 1'b1;
    bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
    assert_rst();
    release_rst();
    idle(2);
    settle();
    n_chk++; if (bus.stall_cycles !== 32'd0 || bus.flush_events !== 32'd0)
      $display("FAIL init_ignore_cnt: got %0d/%0d want 0/0", bus.stall_cycles, bus.flush_events);
    else n_pass++;
  endtask

  task automatic test_load_use();
    assert_rst(); release_rst();
    cyc(ADD_R1, LW5, 0, 0, 1, LU, "lu_rs1");
    cyc(ADD_R1, NOP, 0, 0, 1, IDLE, "lu_resume");
    settle();
    n_chk++; if (bus.flush_events !== 32'd1 || bus.stall_cycles !== 32'd1)
      $display("FAIL lu_cnt: got %0d/%0d want 1/1", bus.flush_events, bus.stall_cycles);
    else n_pass++;
    cyc(ADD000,  LW5,      0, 0, 1, IDLE, "no_dep");
    cyc(ADD000,  LW0,      0, 0, 1, IDLE, "lw_x0");
    cyc(ADD_R2,  LW5,      0, 0, 1, LU,   "lu_rs2");
    cyc(ADDI_F5, LW5,      0, 0, 1, IDLE, "itype_rs2_field");
    cyc(LUI_F5,  LW5,      0, 0, 1, IDLE, "lui_rs1_field");
    cyc(SW5,     LW5,      0, 0, 1, LU,   "lu_store_rs2");
    cyc(BEQ5,    LW5,      0, 0, 1, LU,   "lu_branch_rs2");
    cyc(ADD_R1,  ADDI_RD5, 0, 0, 1, IDLE, "not_a_load");
    idle(1);
    settle();
    n_chk++; if (bus.flush_events !== 32'd4 || bus.stall_cycles !== 32'd4)
      $display("FAIL lu_cnt_total: got %0d/%0d want 4/4", bus.flush_events, bus.stall_cycles);
    else n_pass++;
  endtask

  task automatic test_memstall();
    assert_rst(); release_rst();
    for (int i = 0; i < 4; i++) cyc(NOP, NOP, 0, 1, 0, MEMS, "memstall");
    cyc(NOP, NOP, 0, 1, 1, IDLE, "mem_release");
    idle(1);
    settle();
    n_chk++; if (bus.stall_cycles !== 32'd4 || bus.flush_events !== 32'd0)
      $display("FAIL mem_cnt: got %0d/%0d want 4/0", bus.stall_cycles, bus.flush_events);
    else n_pass++;
    cyc(NOP, NOP, 1, 0, 1, BR, "branch_after_wait");
    idle(1);
    settle();
    n_chk++; if (bus.flush_events !== 32'd1)
      $display("FAIL mem_branch_cnt: got %0d want 1", bus.flush_events);
    else n_pass++;
  endtask

  task automatic test_branch_in_memwait();
    assert_rst(); release_rst();
    cyc(NOP, NOP, 1, 1, 0, MEMS, "br_wait0");
    cyc(NOP, NOP, 1, 1, 0, MEMS, "br_wait1");
    cyc(NOP, NOP, 1, 1, 1, BR,   "br_release");
    idle(2);
    settle();
    n_chk++; if (bus.flush_events !== 32'd1 || bus.stall_cycles !== 32'd2)
      $display("FAIL br_wait_cnt: got %0d/%0d want 1/2", bus.flush_events, bus.stall_cycles);
    else n_pass++;
  endtask

  task automatic test_priority();
    assert_rst(); release_rst();
    cyc(ADD_R1, LW5, 1, 0, 1, BR,   "pc_over_lu");
    cyc(ADD_R1, LW5, 1, 1, 0, MEMS, "mem_over_all");
    cyc(ADD_R1, LW5, 1, 1, 1, BR,   "release_pc_over_lu");
    idle(1);
    settle();
    n_chk++; if (bus.flush_events !== 32'd2 || bus.stall_cycles !== 32'd1)
      $display("FAIL prio_cnt: got %0d/%0d want 2/1", bus.flush_events, bus.stall_cycles);
    else n_pass++;
  endtask

  task automatic test_timeout();
    assert_rst(); release_rst();
    for (int i = 1; i <= 300; i++) begin
      cyc(NOP, NOP, 0, 1, 0, MEMS, "long_wait");
      if (i == 254) begin
        n_chk++; if (bus.mem_timeout !== 1'b0)
          $display("FAIL timeout_early: got %b want 0 at wait %0d", bus.mem_timeout, i);
        else n_pass++;
      end
    end
    n_chk++; if (bus.mem_timeout !== 1'b1)
      $display("FAIL timeout_set: got %b want 1", bus.mem_timeout);
    else n_pass++;
    cyc(NOP, NOP, 0, 1, 1, IDLE, "timeout_release");
    idle(2);
    settle();
    n_chk++; if (bus.mem_timeout !== 1'b1 || bus.stall_cycles !== 32'd300)
      $display("FAIL timeout_sticky: got %b/%0d want 1/300", bus.mem_timeout, bus.stall_cycles);
    else n_pass++;
  endtask

  task automatic test_reset_mid_memwait();
    for (int i = 0; i < 5; i++) cyc(NOP, NOP, 0, 1, 0, MEMS, "pre_abort_wait");
    assert_rst();
    #1;
    n_chk++; if (outs() !== INITV)
      $display("FAIL abort_outputs: got %b want %b", outs(), INITV);
    else n_pass++;
    n_chk++; if (bus.mem_timeout !== 1'b0 || bus.stall_cycles !== 32'd0 || bus.flush_events !== 32'd0)
      $display("FAIL abort_regs: got %b/%0d/%0d want 0/0/0", bus.mem_timeout, bus.stall_cycles, bus.flush_events);
    else n_pass++;
    release_rst();
    idle(2);
    settle();
    n_chk++; if (bus.stall_cycles !== 32'd0)
      $display("FAIL abort_init_cnt: got %0d want 0", bus.stall_cycles);
    else n_pass++;
  endtask

  initial begin
    LW5      = enc(5'd0, 5'd1, 5'd5, OP_LOAD);
    LW0      = enc(5'd0, 5'd1, 5'd0, OP_LOAD);
    ADD_R1   = enc(5'd7, 5'd5, 5'd6, OP_R);
    ADD_R2   = enc(5'd5, 5'd7, 5'd6, OP_R);
    ADD000   = enc(5'd0, 5'd0, 5'd6, OP_R);
    ADDI_F5  = enc(5'd5, 5'd1, 5'd6, OP_IMM);
    LUI_F5   = enc(5'd0, 5'd5, 5'd6, OP_LUI);
    SW5      = enc(5'd5, 5'd1, 5'd0, OP_S);
    BEQ5     = enc(5'd5, 5'd0, 5'd0, OP_B);
    ADDI_RD5 = enc(5'd0, 5'd1, 5'd5, OP_IMM);
    bus.InstrD = NOP; bus.InstrE = NOP; bus.PCSrcE = 1'b0;
    bus.dmem_req = 1'b0; bus.dmem_ready = 1'b1;

    test_reset();
    test_init_ignores();
    test_load_use();
    test_memstall();
    test_branch_in_memwait();
    test_priority();
    test_timeout();
    test_reset_mid_memwait();

    repeat (2) @(posedge clk);
    n_chk++; if (sb.size() != 0)
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 255, is the number of consecutive MEMWAIT cycles after which mem_timeout is raised.
REQ-002 Parameter INIT_CYCLES, default 3, is the number of pipeline-clearing flush cycles after reset release.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 InstrD  input  32  instruction in the decode stage.
REQ-006 InstrE  input  32  instruction in the execute stage.
REQ-007 PCSrcE  input  1  branch or jump taken, resolved in the execute stage.
REQ-008 dmem_req  input  1  memory-stage instruction is accessing data memory.
REQ-009 dmem_ready  input  1  data memory has completed the access this cycle.
REQ-010 StallF, StallD, StallE, StallM  output  1 each  hold the matching pipeline register.
REQ-011 FlushD, FlushE, FlushM  output  1 each  clear the matching pipeline register to a bubble.
REQ-012 mem_timeout  output  1  sticky error flag.
REQ-013 stall_cycles  output  32  performance count of stall cycles.
REQ-014 flush_events  output  32  performance count of flush events.

Function
REQ-015 The FSM SHALL have three states: INIT, RUN and MEMWAIT, with a 2-bit state encoding.
REQ-016 INIT: FlushD, FlushE and FlushM are all 1 and all stalls are 0, for exactly INIT_CYCLES cycles, then the FSM goes to RUN.
REQ-017 A memory stall (memstall) is dmem_req & ~dmem_ready, evaluated in RUN and in MEMWAIT.
REQ-018 On memstall, StallF, StallD, StallE and StallM are 1 in the same cycle (combinational), FlushM is 1, and FlushD and FlushE are 0.
- This holds even when PCSrcE or a load-use hazard is present.
REQ-019 RUN to MEMWAIT happens on memstall. MEMWAIT to RUN happens on the first cycle with ~memstall.
- The release cycle is handled with the RUN output rules.
REQ-020 A load-use hazard (lu) exists when all of the following hold:
- InstrE[6:0] is 0000011.
- rdE = InstrE[11:7] is not 0.
- Either rdE equals InstrD[19:15] and InstrD[6:0] is not one of 0110111, 0010111 or 1101111,
- or rdE equals InstrD[24:20] and InstrD[6:0] is one of 0110011, 0100011 or 1100011.
REQ-021 In RUN with ~memstall and PCSrcE: FlushD and FlushE are 1 and no stall is asserted.
REQ-022 In RUN with ~memstall, ~PCSrcE and lu: StallF, StallD and FlushE are 1 for that cycle only.
- The cycle after, the load has advanced, lu is clear and the pipeline resumes.
REQ-023 Priority is memstall > PCSrcE > lu. PCSrcE and lu cannot originate from the same InstrE; if both are presented, PCSrcE wins.
REQ-024 A PCSrcE held high during MEMWAIT SHALL produce its flush exactly once, in the release cycle.
REQ-025 wait_cnt (8-bit) clears on entry to MEMWAIT and increments each MEMWAIT cycle, saturating at TIMEOUT.
REQ-026 mem_timeout sets to 1 when wait_cnt reaches TIMEOUT.
- It stays 1 until reset.
- The FSM keeps waiting; there is no forced release.
REQ-027 stall_cycles increments by 1 on every cycle with any Stall* = 1, and saturates at 0xFFFFFFFF.
REQ-028 flush_events increments by 1 on every RUN cycle where FlushD or FlushE is asserted by REQ-021 or REQ-022, and saturates at 0xFFFFFFFF.
- INIT flushes and memstall FlushM are not counted.
REQ-029 Stall and flush outputs SHALL be combinational from the state and current inputs; counters and flags are registered.

Reset
REQ-030 While rst_n = 0:
- The state is INIT with the INIT counter at 0.
- wait_cnt = 0, mem_timeout = 0, stall_cycles = 0, flush_events = 0.
- All Stall* = 0 and FlushD, FlushE and FlushM = 1.
REQ-031 Reset asserted mid-MEMWAIT or mid-INIT SHALL abort immediately (asynchronously); INIT restarts after release.
REQ-032 Inputs are ignored during INIT, including dmem_req, PCSrcE and lu.

Verification
REQ-033 Reset release, idle inputs -> Flush* = 1 for exactly 3 cycles, then all outputs 0; counters stay 0.
REQ-034 InstrE = lw x5,0(x1), InstrD = add x6,x5,x7 -> one cycle of StallF = StallD = FlushE = 1; flush_events = 1, stall_cycles = 1. Repeating with add x6,x0,x0 -> no hazard. Repeating with lw x0 as the load -> no hazard.
REQ-035 dmem_req = 1 with dmem_ready low for 4 cycles, then high -> all four stalls and FlushM are 1 for 4 cycles, the FSM returns to RUN, and stall_cycles = 4.
REQ-036 PCSrcE = 1 throughout a 2-cycle memstall -> no FlushD/FlushE during the wait; one FlushD = FlushE = 1 cycle at release; flush_events = 1.
REQ-037 dmem_ready held low for 300 cycles -> mem_timeout rises on wait cycle 255 and stays 1 after release; cleared only by rst_n.
REQ-038 rst_n pulsed low mid-MEMWAIT -> stalls drop immediately, the flag and counters read 0, and a 3-cycle INIT follows.
